// File: rtl/a2d_model_pkg.sv
// Shared constants and state type for the multi-channel SPI A2D slave model.
// Noise injection in the top level is enabled with the ADC_NOISE_EN macro.
package a2d_model_pkg;

    localparam int FRAME_LEN  = 16;
    localparam int ADDR_MSB   = 13;
    localparam int ADDR_LSB   = 11;
    localparam int DATA_MAX_W = 12;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CHECK} a2d_state_t;

endpackage

// File: rtl/adc_multi_ch_model_spi_sync_edge.sv
// Two-flop synchroniser for one SPI bus line, with single-clk rise/fall pulses
// taken from the synchronised level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset to the line's idle level so that leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/adc_multi_ch_model.sv
// N-channel ADC128S-style SPI A2D slave: the address from one frame selects the data
// returned in the next. Define ADC_NOISE_EN to add LFSR noise to the returned data.
module adc_multi_ch_model
    import a2d_model_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 12,
    parameter int NOISE_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     SS_n,
    input  logic                     SCLK,
    input  logic                     MOSI,
    output logic                     MISO,
    input  logic [NUM_CH*DATA_W-1:0] chan_set,
    output logic [15:0]              conv_cnt,
    output logic                     frm_err,
    output logic [2:0]               last_addr
);

    logic w_ss_level, w_ss_rise, w_ss_fall;
    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .i_async(SS_n),
        .o_level(w_ss_level), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(SCLK),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_async(MOSI),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    a2d_state_t            r_state;
    logic [15:0]           r_tx_shft;
    logic [15:0]           r_rx_shft;
    logic [4:0]            r_bit_cnt;
    logic [2:0]            r_ptr;
    logic [2:0]            r_last_addr;
    logic [15:0]           r_conv_cnt;
    logic                  r_frm_err;
    logic                  r_miso;
    logic [DATA_MAX_W-1:0] w_ch [8];
    logic [DATA_MAX_W-1:0] w_sel;
    logic [DATA_MAX_W-1:0] w_data;
    logic [15:0]           w_tx_load;

    // Unmodelled channel slots read as zero, so any 3-bit pointer is safe to decode.
    for (genvar c = 0; c < 8; c++) begin : g_ch
        if (c < NUM_CH) begin : g_real
            assign w_ch[c] = DATA_MAX_W'(chan_set[c*DATA_W +: DATA_W]);
        end else begin : g_none
            assign w_ch[c] = '0;
        end
    end

    assign w_sel = w_ch[r_ptr];

`ifdef ADC_NOISE_EN
    localparam logic signed [DATA_MAX_W+1:0] L_MAX = (DATA_MAX_W+2)'((1 << DATA_W) - 1);

    logic [15:0]                    r_lfsr;
    logic                           w_fb;
    logic signed [NOISE_W-1:0]      w_noise;
    logic signed [DATA_MAX_W+1:0]   w_sum;

    assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_noise = r_lfsr[NOISE_W-1:0];
    assign w_sum   = $signed({2'b00, w_sel}) + (DATA_MAX_W+2)'(w_noise);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (r_state == LOAD) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    // Out-of-range channels stay exactly zero; real channels clamp to the ADC range.
    always_comb begin
        w_data = '0;
        if (r_ptr < 3'(NUM_CH)) begin
            if (w_sum < 0) begin
                w_data = '0;
            end else if (w_sum > L_MAX) begin
                w_data = L_MAX[DATA_MAX_W-1:0];
            end else begin
                w_data = w_sum[DATA_MAX_W-1:0];
            end
        end
    end
`else
    assign w_data = w_sel;
`endif

    assign w_tx_load = {4'b0000, w_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tx_shft   <= '0;
            r_rx_shft   <= '0;
            r_bit_cnt   <= '0;
            r_ptr       <= '0;
            r_last_addr <= '0;
            r_conv_cnt  <= '0;
            r_frm_err   <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_frm_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_miso <= 1'b0;
                    if (w_ss_fall) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_tx_shft <= w_tx_load;
                    r_rx_shft <= '0;
                    r_miso    <= w_tx_load[15];
                    r_bit_cnt <= '0;
                    r_state   <= SHIFT;
                end
                SHIFT: begin
                    if (w_ss_rise) begin
                        r_state <= CHECK;
                    end else begin
                        if (w_sclk_rise) begin
                            r_rx_shft <= {r_rx_shft[14:0], w_mosi};
                            if (r_bit_cnt < 5'd17) begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                        if (w_sclk_fall) begin
                            r_tx_shft <= r_tx_shft << 1;
                            r_miso    <= r_tx_shft[14];
                        end
                    end
                end
                CHECK: begin
                    r_miso <= 1'b0;
                    if (r_bit_cnt == 5'(FRAME_LEN)) begin
                        r_last_addr <= r_rx_shft[ADDR_MSB:ADDR_LSB];
                        r_ptr       <= r_rx_shft[ADDR_MSB:ADDR_LSB];
                        r_conv_cnt  <= r_conv_cnt + 16'd1;
                    end else begin
                        r_frm_err <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = ^{w_mosi_rise, w_mosi_fall, w_ss_level, w_sclk_level,
                        r_rx_shft[15], (NOISE_W > 0)};

    assign MISO      = r_miso;
    assign conv_cnt  = r_conv_cnt;
    assign frm_err   = r_frm_err;
    assign last_addr = r_last_addr;

endmodule

// File: tb/tb_adc_multi_ch_model.sv
// Scoreboard bench for adc_multi_ch_model: an SPI master issues frames, expected MISO
// words are queued at issue and checked by a separate monitor as frames complete.
module tb_adc_multi_ch_model;

    localparam int NUM_CH = 6;
    localparam int DATA_W = 12;
    localparam int HALF   = 6;

    logic                     clk   = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     SS_n  = 1'b1;
    logic                     SCLK  = 1'b0;
    logic                     MOSI  = 1'b0;
    logic [NUM_CH*DATA_W-1:0] chan_set;
    wire                      MISO;
    wire  [15:0]              conv_cnt;
    wire                      frm_err;
    wire  [2:0]               last_addr;

    adc_multi_ch_model #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .NOISE_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .chan_set(chan_set), .conv_cnt(conv_cnt), .frm_err(frm_err), .last_addr(last_addr)
    );

    always #5 clk = ~clk;

    int          errors    = 0;
    int          checks    = 0;
    int          errCycles = 0;
    logic [15:0] expQ[$];
    logic [15:0] capQ[$];
    logic [11:0] chVal [NUM_CH];
    int          modelPtr  = 0;
    int          modelConv = 0;
    int          modelLast = 0;

    always_comb begin
        chan_set = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            chan_set[c*DATA_W +: DATA_W] = chVal[c];
        end
    end

    always @(negedge clk) begin
        if (frm_err === 1'b1) errCycles++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every captured frame is compared against the oldest expected word.
    initial begin
        logic [15:0] cap;
        forever begin
            @(negedge clk);
            if (capQ.size() > 0) begin
                cap = capQ.pop_front();
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard_underflow: got 0x%0h, expected none", cap);
                end else begin
                    checkOutput("miso_frame", {16'h0, cap}, {16'h0, expQ.pop_front()});
                end
            end
        end
    end

    // Drive one frame; resetAt >= 0 asserts reset at that bit and leaves it asserted.
    task automatic applyStimulus(input int addr, input int nBits, input bit scored,
                                 input int resetAt, output logic [15:0] word);
        logic [15:0] mosiWord;
        logic [2:0]  a;
        a        = addr[2:0];
        mosiWord = {2'b00, a, 11'b0};
        word     = '0;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nBits; i++) begin
            if (i == resetAt) begin
                rst_n = 1'b0;
                SS_n  = 1'b1;
                SCLK  = 1'b0;
                MOSI  = 1'b0;
                return;
            end
            MOSI = mosiWord[15-i];
            repeat (HALF) @(negedge clk);
            word[15-i] = MISO;
            SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        SS_n = 1'b1;
        repeat (10) @(negedge clk);
        MOSI = 1'b0;
        if (scored && nBits == 16) capQ.push_back(word);
    endtask

    function automatic logic [15:0] modelData(input int p);
        return (p < NUM_CH) ? {4'h0, chVal[p]} : 16'h0000;
    endfunction

    task automatic fullFrame(input int addr);
        logic [15:0] w;
        expQ.push_back(modelData(modelPtr));
        applyStimulus(addr, 16, 1'b1, -1, w);
        modelPtr  = addr;
        modelConv = (modelConv + 1) & 16'hFFFF;
        modelLast = addr;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] w;
        bit          anyDiff;
        chVal[0] = 12'h205;
        chVal[1] = 12'h5C3;
        chVal[2] = 12'h111;
        chVal[3] = 12'h7E8;
        chVal[4] = 12'h0FF;
        chVal[5] = 12'h3A7;

        repeat (5) @(negedge clk);
        checkOutput("reset_miso", {31'h0, MISO}, 0);
        checkOutput("reset_conv_cnt", {16'h0, conv_cnt}, 0);
        checkOutput("reset_frm_err", {31'h0, frm_err}, 0);
        checkOutput("reset_last_addr", {29'h0, last_addr}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        fullFrame(0);
        checkOutput("t1_conv_cnt", {16'h0, conv_cnt}, modelConv);
        checkOutput("t1_last_addr", {29'h0, last_addr}, modelLast);

        fullFrame(4);
        fullFrame(5);
        fullFrame(1);
        checkOutput("t2_conv_cnt", {16'h0, conv_cnt}, modelConv);
        checkOutput("t2_last_addr", {29'h0, last_addr}, modelLast);

        applyStimulus(3, 9, 1'b0, -1, w);
        checkOutput("t3_frm_err_cycles", errCycles, 1);
        checkOutput("t3_conv_cnt_hold", {16'h0, conv_cnt}, modelConv);
        checkOutput("t3_last_addr_hold", {29'h0, last_addr}, modelLast);
        fullFrame(6);

        fullFrame(7);
        fullFrame(2);
        checkOutput("t4_conv_cnt", {16'h0, conv_cnt}, modelConv);
        checkOutput("t4_last_addr", {29'h0, last_addr}, modelLast);
        checkOutput("t4_frm_err_cycles", errCycles, 1);

        applyStimulus(3, 16, 1'b0, 7, w);
        @(negedge clk);
        checkOutput("t5_reset_miso", {31'h0, MISO}, 0);
        checkOutput("t5_reset_conv_cnt", {16'h0, conv_cnt}, 0);
        checkOutput("t5_reset_last_addr", {29'h0, last_addr}, 0);
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        modelPtr  = 0;
        modelConv = 0;
        modelLast = 0;
        repeat (4) @(negedge clk);
        fullFrame(1);
        checkOutput("t5_conv_cnt", {16'h0, conv_cnt}, modelConv);

        chVal[1] = 12'hFFF;
        anyDiff  = 1'b0;
        for (int f = 0; f < 12; f++) begin
            applyStimulus(1, 16, 1'b0, -1, w);
            modelConv++;
`ifdef ADC_NOISE_EN
            checkOutput("t6_noise_in_range", {31'h0, (w <= 16'h0FFF)}, 1);
            if (w != 16'h0FFF) anyDiff = 1'b1;
`else
            checkOutput("t6_exact_value", {16'h0, w}, 32'h0FFF);
`endif
        end
`ifdef ADC_NOISE_EN
        checkOutput("t6_noise_seen", {31'h0, anyDiff}, 1);
`endif
        checkOutput("t6_conv_cnt", {16'h0, conv_cnt}, modelConv);
        checkOutput("t6_frm_err_cycles", errCycles, 1);

        for (int t = 0; t < 100 && capQ.size() > 0; t++) @(negedge clk);
        checkOutput("scoreboard_drained", capQ.size(), 0);
        checkOutput("scoreboard_leftover", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
